// File: rtl/sd_spi_controller_if.sv
// Signal bundle of the SD SPI command engine: host request/status, response
// buffer write port and the four card pins.
interface sd_spi_controller_if #(
    parameter int MEMORY_SIZE_IN_BYTES = 30
);
    localparam int AW = $clog2(MEMORY_SIZE_IN_BYTES);

    // Card pins
    logic          sclk;
    logic          mosi;
    logic          miso;
    logic          ss;

    // Command and raw-transfer requests
    logic          start;
    logic [5:0]    cmd;
    logic [31:0]   arg;
    logic [6:0]    crc;
    logic [AW-1:0] nresponse;
    logic          raw_start;
    logic [AW-1:0] raw_size;
    logic [7:0]    raw_data;
    logic          raw_ss;

    // Response buffer write port and status
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          done;
    logic          busy;
    logic          timeout;

    modport slave (
        input  miso, start, cmd, arg, crc, nresponse,
               raw_start, raw_size, raw_data, raw_ss,
        output sclk, mosi, ss, mem_wr, mem_addr, mem_data, done, busy, timeout
    );

    modport master (
        output miso, start, cmd, arg, crc, nresponse,
               raw_start, raw_size, raw_data, raw_ss,
        input  sclk, mosi, ss, mem_wr, mem_addr, mem_data, done, busy, timeout
    );
endinterface

// File: rtl/sd_spi_controller.sv
// SPI-mode SD card command engine: sends raw filler bytes or 6-byte commands
// over a mode-0 SPI master at clk/2 and writes the card's response bytes out.
module sd_spi_controller #(
    parameter int MEMORY_SIZE_IN_BYTES = 30
) (
    input  logic               clk,
    input  logic               rst_n,
    sd_spi_controller_if.slave bus
);
    localparam int AW = $clog2(MEMORY_SIZE_IN_BYTES);
    localparam int CW = (AW > 3) ? AW : 3;

    typedef enum logic [2:0] {
        IDLE,
        RAW,
        CMD_TX,
        POLL,
        RESP,
        FINISH
    } state_t;

    state_t        state, state_d;

    logic [3:0]    phase;
    logic [47:0]   tx_sh;
    logic [7:0]    rx_sh;
    logic [CW-1:0] byte_cnt;
    logic [2:0]    poll_cnt;
    logic [AW-1:0] resp_idx;
    logic          fin_stop;

    logic [AW-1:0] nresp_q;
    logic [AW-1:0] raw_size_q;
    logic [7:0]    raw_data_q;

    logic          ss_q;
    logic          done_q;
    logic          timeout_q;
    logic          mem_wr_q;
    logic [AW-1:0] mem_addr_q;
    logic [7:0]    mem_data_q;

    logic          accept_cmd;
    logic          accept_raw;
    logic          shifting;
    logic          byte_end;
    logic          hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d    = state;
        accept_cmd = 1'b0;
        accept_raw = 1'b0;
        // FINISH shifts only while its trailing byte is still going out
        shifting   = (state inside {RAW, CMD_TX, POLL, RESP}) ||
                     (state == FINISH && !fin_stop);
        byte_end   = shifting && (phase == 4'd15);
        hit        = !rx_sh[7];

        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept_cmd = 1'b1;
                    state_d    = CMD_TX;
                end else if (bus.raw_start) begin
                    accept_raw = 1'b1;
                    state_d    = RAW;
                end
            end
            RAW: begin
                if (byte_end && byte_cnt == CW'(raw_size_q)) state_d = FINISH;
            end
            CMD_TX: begin
                if (byte_end && byte_cnt == CW'(5))
                    state_d = (nresp_q != '0) ? POLL : FINISH;
            end
            POLL: begin
                if (byte_end) begin
                    if (hit)                    state_d = (nresp_q == AW'(1)) ? FINISH : RESP;
                    else if (poll_cnt == 3'd7)  state_d = FINISH;
                end
            end
            RESP: begin
                if (byte_end && resp_idx == nresp_q - AW'(1)) state_d = FINISH;
            end
            FINISH: begin
                if (fin_stop) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state is assigned with <= only; later assignments in
    // the same edge deliberately override earlier ones (byte reloads).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase      <= '0;
            tx_sh      <= '1;
            rx_sh      <= '0;
            byte_cnt   <= '0;
            poll_cnt   <= '0;
            resp_idx   <= '0;
            fin_stop   <= 1'b0;
            nresp_q    <= '0;
            raw_size_q <= '0;
            raw_data_q <= '0;
            ss_q       <= 1'b1;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            mem_wr_q <= 1'b0;
            done_q   <= 1'b0;

            if (accept_cmd || accept_raw) begin
                phase     <= '0;
                byte_cnt  <= '0;
                poll_cnt  <= '0;
                resp_idx  <= '0;
                fin_stop  <= 1'b0;
                timeout_q <= 1'b0;
            end

            if (accept_cmd) begin
                // Whole frame in one register; 1-fill makes later bytes 0xFF
                tx_sh   <= {2'b01, bus.cmd, bus.arg, bus.crc, 1'b1};
                nresp_q <= bus.nresponse;
                ss_q    <= 1'b0;
            end else if (accept_raw) begin
                tx_sh      <= {bus.raw_data, 40'hFF_FFFF_FFFF};
                raw_size_q <= bus.raw_size;
                raw_data_q <= bus.raw_data;
                ss_q       <= bus.raw_ss;
            end else if (shifting) begin
                phase <= phase + 4'd1;
                if (!phase[0]) rx_sh <= {rx_sh[6:0], bus.miso};
                else           tx_sh <= {tx_sh[46:0], 1'b1};

                // Eighth bit is being sampled now; rx_sh[6] is the byte's bit 7
                if (phase == 4'd14 &&
                    (state == RESP || (state == POLL && !rx_sh[6]))) begin
                    mem_wr_q   <= 1'b1;
                    mem_addr_q <= resp_idx;
                    mem_data_q <= {rx_sh[6:0], bus.miso};
                end

                if (byte_end) begin
                    byte_cnt <= byte_cnt + CW'(1);
                    case (state)
                        RAW: begin
                            if (state_d == RAW) tx_sh <= {raw_data_q, 40'hFF_FFFF_FFFF};
                        end
                        POLL: begin
                            if (hit) begin
                                resp_idx <= resp_idx + AW'(1);
                            end else begin
                                poll_cnt <= poll_cnt + 3'd1;
                                if (poll_cnt == 3'd7) timeout_q <= 1'b1;
                            end
                        end
                        RESP:    resp_idx <= resp_idx + AW'(1);
                        default: ;
                    endcase

                    if (state == FINISH)       fin_stop <= 1'b1;
                    else if (state_d == FINISH) fin_stop <= (state == RAW);
                end
            end else if (state == FINISH) begin
                ss_q   <= 1'b1;
                done_q <= 1'b1;
            end
        end
    end

    assign bus.sclk     = shifting & phase[0];
    assign bus.mosi     = shifting ? tx_sh[47] : 1'b1;
    assign bus.ss       = ss_q;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_q;
    assign bus.timeout  = timeout_q;
    assign bus.mem_wr   = mem_wr_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_data = mem_data_q;

endmodule

// File: tb/tb_sd_spi_controller.sv
// Directed bench for sd_spi_controller: scoreboards the mosi byte stream and
// response-buffer writes against a small SD card model driving miso.
module tb_sd_spi_controller;
    localparam int MEM = 30;
    localparam int AW  = $clog2(MEM);

    typedef struct {
        logic [7:0] data;
        logic       ss;
    } spi_byte_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } mem_wr_t;

    logic clk = 1'b0;
    logic rst_n;

    sd_spi_controller_if #(.MEMORY_SIZE_IN_BYTES(MEM)) bus ();

    sd_spi_controller #(.MEMORY_SIZE_IN_BYTES(MEM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    spi_byte_t mosi_q[$];
    mem_wr_t   mem_q[$];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Card model: answers with card_resp[] after the 48 command bits, then 0xFF
    logic [7:0] card_resp [8];
    int         card_len = 0;
    int         card_bit = 0;
    logic       card_miso;

    always @(negedge bus.sclk or posedge bus.ss or negedge rst_n) begin
        if (!rst_n || bus.ss) card_bit = 0;
        else                  card_bit = card_bit + 1;
    end

    always_comb begin
        card_miso = 1'b1;
        if (card_bit >= 48 && ((card_bit - 48) / 8) < card_len)
            card_miso = card_resp[(card_bit - 48) / 8][7 - ((card_bit - 48) % 8)];
    end

    assign bus.miso = card_miso;

    // mosi monitor: assembles bytes on sclk rises and scores them
    int         sclk_rises = 0;
    int         mon_bits = 0;
    logic [7:0] mon_sh = 8'h00;
    spi_byte_t  mon_exp;

    always @(posedge bus.sclk or negedge rst_n) begin
        if (!rst_n) begin
            mon_bits = 0;
        end else begin
            sclk_rises++;
            mon_sh = {mon_sh[6:0], bus.mosi};
            mon_bits++;
            if (mon_bits == 8) begin
                mon_bits = 0;
                check("mosi_byte_expected", 32'(mosi_q.size() != 0), 1);
                if (mosi_q.size() != 0) begin
                    mon_exp = mosi_q.pop_front();
                    check("mosi_byte", mon_sh, mon_exp.data);
                    check("ss_during_byte", bus.ss, mon_exp.ss);
                end
            end
        end
    end

    // Response-buffer write monitor, sampled away from the active edge
    mem_wr_t wr_exp;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.mem_wr === 1'b1) begin
            check("mem_wr_expected", 32'(mem_q.size() != 0), 1);
            if (mem_q.size() != 0) begin
                wr_exp = mem_q.pop_front();
                check("mem_addr", bus.mem_addr, wr_exp.addr);
                check("mem_data", bus.mem_data, wr_exp.data);
            end
        end
    end

    task automatic push_byte(input logic [7:0] data, input logic ss);
        spi_byte_t b;
        b.data = data;
        b.ss   = ss;
        mosi_q.push_back(b);
    endtask

    task automatic push_ff(input int n, input logic ss);
        for (int i = 0; i < n; i++) push_byte(8'hFF, ss);
    endtask

    task automatic push_cmd(input logic [5:0] c, input logic [31:0] a, input logic [6:0] r);
        push_byte({2'b01, c}, 1'b0);
        push_byte(a[31:24], 1'b0);
        push_byte(a[23:16], 1'b0);
        push_byte(a[15:8], 1'b0);
        push_byte(a[7:0], 1'b0);
        push_byte({r, 1'b1}, 1'b0);
    endtask

    task automatic push_wr(input logic [AW-1:0] addr, input logic [7:0] data);
        mem_wr_t w;
        w.addr = addr;
        w.data = data;
        mem_q.push_back(w);
    endtask

    // Request inputs are set by the caller before a negedge; this consumes the accepting edge
    task automatic accept(input logic exp_ss, input string tag);
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.raw_start = 1'b0;
        check({tag, "_busy_after_accept"}, bus.busy, 1);
        check({tag, "_ss_after_accept"}, bus.ss, exp_ss);
        check({tag, "_sclk_after_accept"}, bus.sclk, 0);
    endtask

    task automatic wait_done(input int exp_cycles, input string tag);
        int cyc = 0;
        int first_rise = 0;
        while (cyc < 3000) begin
            @(posedge clk);
            cyc++;
            #1;
            if (first_rise == 0 && bus.sclk === 1'b1) first_rise = cyc;
            if (bus.done === 1'b1) break;
        end
        check({tag, "_done_cycle"}, cyc, exp_cycles);
        check({tag, "_first_sclk_cycle"}, first_rise, 1);
        check({tag, "_ss_at_done"}, bus.ss, 1);
        check({tag, "_busy_at_done"}, bus.busy, 0);
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, bus.done, 0);
        check({tag, "_mosi_drained"}, mosi_q.size(), 0);
        check({tag, "_mem_drained"}, mem_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ss"}, bus.ss, 1);
        check({tag, "_sclk"}, bus.sclk, 0);
        check({tag, "_mosi"}, bus.mosi, 1);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_mem_wr"}, bus.mem_wr, 0);
        check({tag, "_mem_addr"}, bus.mem_addr, 0);
        check({tag, "_mem_data"}, bus.mem_data, 0);
        check({tag, "_timeout"}, bus.timeout, 0);
    endtask

    initial begin
        int  r0;
        bit  idle_bad;

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.raw_start = 1'b0;
        bus.cmd       = '0;
        bus.arg       = '0;
        bus.crc       = '0;
        bus.nresponse = '0;
        bus.raw_size  = '0;
        bus.raw_data  = '0;
        bus.raw_ss    = 1'b1;
        for (int i = 0; i < 8; i++) card_resp[i] = 8'hFF;

        // Reset state and a quiet idle period
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        r0 = sclk_rises;
        idle_bad = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (bus.ss !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.mosi !== 1'b1)
                idle_bad = 1'b1;
        end
        check("idle_outputs_stable", idle_bad, 0);
        check("idle_no_sclk", sclk_rises - r0, 0);

        // Raw power-up clocks: 16 bytes of 0xFF with ss high
        push_ff(16, 1'b1);
        r0 = sclk_rises;
        @(negedge clk);
        bus.raw_size  = AW'(15);
        bus.raw_data  = 8'hFF;
        bus.raw_ss    = 1'b1;
        bus.raw_start = 1'b1;
        accept(1'b1, "raw");
        wait_done(257, "raw");
        check("raw_sclk_pulses", sclk_rises - r0, 128);

        // CMD0 with no response capture
        push_cmd(6'd0, 32'h0, 7'h4A);
        push_ff(1, 1'b0);
        @(negedge clk);
        bus.cmd       = 6'd0;
        bus.arg       = 32'h0;
        bus.crc       = 7'h4A;
        bus.nresponse = '0;
        bus.start     = 1'b1;
        accept(1'b0, "cmd0");
        wait_done(113, "cmd0");

        // CMD0 with R1 arriving in the third poll byte
        card_resp[0] = 8'hFF;
        card_resp[1] = 8'hFF;
        card_resp[2] = 8'h01;
        card_len     = 3;
        push_cmd(6'd0, 32'h0, 7'h4A);
        push_ff(3 + 1, 1'b0);
        push_wr(AW'(0), 8'h01);
        @(negedge clk);
        bus.nresponse = AW'(1);
        bus.start     = 1'b1;
        accept(1'b0, "r1");
        wait_done(161, "r1");
        check("r1_timeout", bus.timeout, 0);

        // Card never answers: eight poll bytes then timeout
        card_len = 0;
        push_cmd(6'd0, 32'h0, 7'h4A);
        push_ff(8 + 1, 1'b0);
        @(negedge clk);
        bus.start = 1'b1;
        accept(1'b0, "tmo");
        wait_done(241, "tmo");
        check("tmo_timeout", bus.timeout, 1);

        // start and raw_start together: the command wins; reset lands mid-byte
        push_cmd(6'd8, 32'h0000_01AA, 7'h43);
        @(negedge clk);
        bus.cmd       = 6'd8;
        bus.arg       = 32'h0000_01AA;
        bus.crc       = 7'h43;
        bus.nresponse = '0;
        bus.raw_size  = AW'(3);
        bus.raw_data  = 8'h00;
        bus.raw_ss    = 1'b1;
        bus.start     = 1'b1;
        bus.raw_start = 1'b1;
        accept(1'b0, "prio");
        check("prio_timeout_cleared", bus.timeout, 0);
        repeat (37) @(posedge clk);
        #2;
        check("prio_sclk_high_before_reset", bus.sclk, 1);
        check("prio_busy_before_reset", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midbyte_reset");
        mosi_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // After reset: CMD17 with a three-byte response
        card_resp[0] = 8'hFF;
        card_resp[1] = 8'h00;
        card_resp[2] = 8'hAB;
        card_resp[3] = 8'hCD;
        card_len     = 4;
        push_cmd(6'd17, 32'h0000_0200, 7'h2A);
        push_ff(2 + 2 + 1, 1'b0);
        push_wr(AW'(0), 8'h00);
        push_wr(AW'(1), 8'hAB);
        push_wr(AW'(2), 8'hCD);
        @(negedge clk);
        bus.cmd       = 6'd17;
        bus.arg       = 32'h0000_0200;
        bus.crc       = 7'h2A;
        bus.nresponse = AW'(3);
        bus.start     = 1'b1;
        accept(1'b0, "resp3");
        wait_done(177, "resp3");
        check("resp3_timeout", bus.timeout, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
